prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// Program loader / instruction sequencer for an external asynchronous-read program RAM.
// Optional build macro PROG_SEQ_LOOP_EN: wrap from the last word back to word 0 while run stays high.
module prog_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 5,
  parameter logic [WIDTH-1:0] HALT_OP = '1,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             run,
  input  logic [WIDTH-1:0] instruction,
  input  logic             instr_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [AW-1:0]    address,
  output logic [WIDTH-1:0] instr_out,
  output logic             instr_valid,
  output logic             master_clear,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] Last = AW'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StLoaded, StFetch, StIssue, StHalt} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    count_q, count_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             mc_q, mc_d;
  logic [WIDTH-1:0] iout_q, iout_d;
  logic             iv_q, iv_d;
  logic             busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mc_d      = 1'b0;
    iout_d    = iout_q;
    iv_d      = iv_q;
    unique case (state_q)
      StIdle, StLoad, StLoaded, StHalt: begin
        if (load_valid) begin
          // Any accept outside LOAD starts a fresh program at word 0.
          wr_en_d   = 1'b1;
          wr_data_d = load_data;
          wr_addr_d = (state_q == StLoad) ? count_q : '0;
          if (state_q == StLoad && count_q == Last) begin
            state_d = StLoaded;
            count_d = '0;
            mc_d    = 1'b1;
          end else begin
            state_d = StLoad;
            count_d = wr_addr_d + 1'b1;
          end
        end else if (state_q == StLoaded && run) begin
          addr_d  = '0;
          state_d = StFetch;
        end else if (state_q == StHalt && !run) begin
          addr_d  = '0;
          state_d = StLoaded;
        end
      end
      StFetch: begin
        if (instruction == HALT_OP) begin
          state_d = StHalt;
        end else begin
          iout_d  = instruction;
          iv_d    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          iv_d = 1'b0;
          if (addr_q != Last) begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end else begin
`ifdef PROG_SEQ_LOOP_EN
            if (run) begin
              addr_d  = '0;
              state_d = StFetch;
            end else begin
              state_d = StHalt;
            end
`else
            state_d = StHalt;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= StIdle;
      count_q   <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mc_q      <= 1'b0;
      iout_q    <= '0;
      iv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mc_q      <= mc_d;
      iout_q    <= iout_d;
      iv_q      <= iv_d;
      busy_q    <= (state_d == StLoad) || (state_d == StFetch) || (state_d == StIssue);
      done_q    <= (state_d == StHalt);
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign address      = addr_q;
  assign instr_out    = iout_q;
  assign instr_valid  = iv_q;
  assign master_clear = mc_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
